nth_root_seq: RTL and testbench

Parametrised iterative fixed-point n-th root unit. It computes floor(x^(1/n) * 2^FRAC_W) for an unsigned integer x and a runtime exponent n, resolving one result bit per trial. The (n-1) multiplies of each trial run on a single sequential multiplier. Valid/ready handshakes on both sides let it sit between a command source and a result consumer in the arithmetic datapath.

---
 rtl/nth_root_pkg.sv | 26 ++
 rtl/nth_root_seq_pow.sv | 72 +++++++
 rtl/nth_root_seq.sv | 148 ++++++++++++++
 tb/tb_nth_root_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nth_root_pkg.sv
// Shared types and width helpers for the n-th root unit.
// Imported by the top level and the power sub-unit.
package nth_root_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        MUL,
        CMP,
        DONE,
        ERR
    } state_e;

    function automatic int calc_out_w(input int in_w, input int frac_w);
        return in_w + frac_w;
    endfunction

    function automatic int calc_acc_w(input int n_max, input int out_w);
        return n_max * out_w;
    endfunction

    function automatic logic n_in_range(input int n, input int n_max);
        return (n >= 1) && (n <= n_max);
    endfunction

endpackage

// File: rtl/nth_root_seq_pow.sv
// Sequential power unit: raises candidate c to the n-th power one
// multiply per cycle, stopping early once the product exceeds t.
module root_pow_unit
    import nth_root_pkg::*;
#(
    parameter int OUT_W = 25,
    parameter int ACC_W = 175,
    parameter int N_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OUT_W-1:0] c,
    input  logic [N_W-1:0]   n,
    input  logic [ACC_W-1:0] t,
    output logic             busy,
    output logic             done,
    output logic             le,
    output logic             eq
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] prod;
    logic [N_W-1:0]   k_q, k_d;
    logic [N_W-1:0]   k_inc;
    logic             busy_q, busy_d;
    logic             over;
    logic             last;
    logic             full;

    // c^k < 2^(k*OUT_W), so the truncated product never loses bits
    assign prod  = acc_q * {{(ACC_W-OUT_W){1'b0}}, c};
    assign k_inc = k_q + N_W'(1);
    assign over  = prod > t;
    assign last  = over || (k_inc == n);
    assign full  = (k_q == n);

    assign busy = busy_q;
    assign done = busy_q && last;
    assign le   = full && (acc_q <= t);
    assign eq   = full && (acc_q == t);

    // Load on start, then one multiply step per cycle while busy
    always_comb begin
        acc_d  = acc_q;
        k_d    = k_q;
        busy_d = busy_q;
        if (start) begin
            acc_d  = {{(ACC_W-OUT_W){1'b0}}, c};
            k_d    = N_W'(1);
            busy_d = (n != N_W'(1));
        end else if (busy_q) begin
            acc_d  = prod;
            k_d    = k_inc;
            busy_d = !last;
        end
    end

    // Power accumulator state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            k_q    <= '0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            k_q    <= k_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/nth_root_seq.sv
// Iterative fixed-point n-th root: one result bit per trial, the
// trial power computed on a shared sequential multiplier.
module nth_root_seq
    import nth_root_pkg::*;
#(
    parameter int IN_W   = 10,
    parameter int FRAC_W = 15,
    parameter int N_MAX  = 7,
    parameter int N_W    = 3,
    localparam int OUT_W = calc_out_w(IN_W, FRAC_W),
    localparam int ACC_W = calc_acc_w(N_MAX, OUT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_x,
    input  logic [N_W-1:0]   in_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    localparam int BW = $clog2(OUT_W);

    state_e           state_q, state_d;
    logic [OUT_W-1:0] r_q, r_d;
    logic [BW-1:0]    b_q, b_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [ACC_W-1:0] t_q, t_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             err_q, err_d;

    logic [OUT_W-1:0] c;
    logic [ACC_W-1:0] t_in;
    logic             accept;
    logic             pow_start;
    logic             pow_busy;
    logic             pow_done;
    logic             pow_le;
    logic             pow_eq;

    assign c         = r_q | (OUT_W'(1) << b_q);
    assign t_in      = ACC_W'(in_x) << (32'(in_n) * FRAC_W);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE) || (state_q == ERR);
    assign out_data  = data_q;
    assign out_err   = err_q;
    assign accept    = in_valid && in_ready;
    assign pow_start = (state_q == SETUP);

    root_pow_unit #(
        .OUT_W (OUT_W),
        .ACC_W (ACC_W),
        .N_W   (N_W)
    ) u_pow (
        .clk   (clk),
        .rst_n (rst_n),
        .start (pow_start),
        .c     (c),
        .n     (n_q),
        .t     (t_q),
        .busy  (pow_busy),
        .done  (pow_done),
        .le    (pow_le),
        .eq    (pow_eq)
    );

    // Handshake FSM and bit-by-bit result refinement
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        b_d     = b_q;
        n_d     = n_q;
        t_d     = t_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    n_d = in_n;
                    t_d = t_in;
                    if (!n_in_range(32'(in_n), N_MAX)) begin
                        state_d = ERR;
                        data_d  = '0;
                        err_d   = 1'b1;
                    end else begin
                        r_d     = '0;
                        b_d     = BW'(OUT_W - 1);
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                state_d = (n_q == N_W'(1)) ? CMP : MUL;
            end
            MUL: begin
                if (pow_done || !pow_busy) begin
                    state_d = CMP;
                end
            end
            CMP: begin
                if (pow_le) begin
                    r_d = c;
                end
                if (pow_eq || (b_q == '0)) begin
                    state_d = DONE;
                    data_d  = pow_le ? c : r_q;
                    err_d   = 1'b0;
                end else begin
                    b_d     = b_q - BW'(1);
                    state_d = SETUP;
                end
            end
            DONE, ERR: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            t_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            b_q     <= b_d;
            n_q     <= n_d;
            t_q     <= t_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_nth_root_seq.sv
// Directed-vector bench for nth_root_seq.
// A second instance with N_MAX=6 exercises the out-of-range error.
module tb_nth_root_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  in_x = '0;
    logic [2:0]  in_n = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [24:0] out_data;
    logic        out_err;

    logic        e_in_valid = 1'b0;
    logic        e_in_ready;
    logic [9:0]  e_in_x = '0;
    logic [2:0]  e_in_n = '0;
    logic        e_out_valid;
    logic        e_out_ready = 1'b0;
    logic [24:0] e_out_data;
    logic        e_out_err;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    nth_root_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_n      (in_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    nth_root_seq #(.N_MAX(6)) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (e_in_valid),
        .in_ready  (e_in_ready),
        .in_x      (e_in_x),
        .in_n      (e_in_n),
        .out_valid (e_out_valid),
        .out_ready (e_out_ready),
        .out_data  (e_out_data),
        .out_err   (e_out_err)
    );

    function automatic logic [191:0] ipow(input logic [191:0] y,
                                          input int n);
        logic [191:0] p;
        p = 192'd1;
        for (int i = 0; i < n; i++) p = p * y;
        return p;
    endfunction

    // Real-valued estimate corrected by exact integer bracketing
    function automatic int golden(input int x, input int n);
        logic [191:0] t;
        real est;
        int y;
        t = 192'(x) << (n * 15);
        est = $pow(real'(x), 1.0 / real'(n)) * 32768.0;
        y = $rtoi(est);
        while (ipow(192'(y + 1), n) <= t) y++;
        while (y > 0 && ipow(192'(y), n) > t) y--;
        return y;
    endfunction

    task automatic send(input int x, input int n);
        in_x = x[9:0];
        in_n = n[2:0];
        in_valid = 1'b1;
        vecs++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL send_ready: in_ready=%0b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int limit, output int lat,
                            output bit busy_ok);
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < limit) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vecs++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL rst_ready: got %0b want 1", in_ready);
        end
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL rst_valid: got %0b want 0", out_valid);
        end
        vecs++;
        if (out_data !== 25'd0) begin
            errs++;
            $display("FAIL rst_data: got %0d want 0", out_data);
        end
        vecs++;
        if (out_err !== 1'b0) begin
            errs++;
            $display("FAIL rst_err: got %0b want 0", out_err);
        end
    endtask

    task automatic test_exact();
        int lat;
        bit ok;
        send(8, 3);
        wait_out(300, lat, ok);
        vecs++;
        if (out_valid !== 1'b1) begin
            errs++;
            $display("FAIL cube8_timeout: valid=%0b want 1", out_valid);
        end
        vecs++;
        if (out_data !== 25'd65536) begin
            errs++;
            $display("FAIL cube8_data: got %0d want 65536", out_data);
        end
        vecs++;
        if (out_err !== 1'b0) begin
            errs++;
            $display("FAIL cube8_err: got %0b want 0", out_err);
        end
        vecs++;
        if (lat >= 101) begin
            errs++;
            $display("FAIL cube8_lat: got %0d want <101", lat);
        end
        take();
    endtask

    task automatic test_sqrt_and_n1();
        int lat;
        bit ok;
        send(2, 2);
        wait_out(300, lat, ok);
        vecs++;
        if (out_valid !== 1'b1 || out_data !== 25'd46340) begin
            errs++;
            $display("FAIL sqrt2: valid=%0b data=%0d want 1/46340",
                     out_valid, out_data);
        end
        take();
        send(1023, 1);
        wait_out(300, lat, ok);
        vecs++;
        if (out_valid !== 1'b1 || out_data !== 25'd33521664) begin
            errs++;
            $display("FAIL n1: valid=%0b data=%0d want 1/33521664",
                     out_valid, out_data);
        end
        take();
    endtask

    task automatic test_seventh();
        int lat;
        bit ok;
        int exp_v;
        exp_v = golden(1023, 7);
        send(1023, 7);
        wait_out(400, lat, ok);
        vecs++;
        if (out_valid !== 1'b1 || out_data !== 25'(exp_v)) begin
            errs++;
            $display("FAIL root7: valid=%0b data=%0d want 1/%0d",
                     out_valid, out_data, exp_v);
        end
        vecs++;
        if (lat > 201) begin
            errs++;
            $display("FAIL root7_lat: got %0d want <=201", lat);
        end
        vecs++;
        if (ok !== 1'b1) begin
            errs++;
            $display("FAIL root7_busy: in_ready seen high, want 0");
        end
        take();
    endtask

    task automatic test_err();
        int lat;
        bit ok;
        send(5, 0);
        wait_out(50, lat, ok);
        vecs++;
        if (lat !== 1 || out_valid !== 1'b1) begin
            errs++;
            $display("FAIL n0_lat: lat=%0d valid=%0b want 1/1",
                     lat, out_valid);
        end
        vecs++;
        if (out_err !== 1'b1 || out_data !== 25'd0) begin
            errs++;
            $display("FAIL n0_out: err=%0b data=%0d want 1/0",
                     out_err, out_data);
        end
        take();
        vecs++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL n0_release: rdy=%0b valid=%0b want 1/0",
                     in_ready, out_valid);
        end
        for (int i = 0; i < 2; i++) begin
            e_in_x = 10'd5;
            e_in_n = (i == 0) ? 3'd7 : 3'd0;
            e_in_valid = 1'b1;
            @(posedge clk);
            #1;
            e_in_valid = 1'b0;
            vecs++;
            if (e_out_valid !== 1'b1 || e_out_err !== 1'b1 ||
                e_out_data !== 25'd0) begin
                errs++;
                $display("FAIL nmax6_err%0d: v=%0b e=%0b d=%0d want 1/1/0",
                         i, e_out_valid, e_out_err, e_out_data);
            end
            e_out_ready = 1'b1;
            @(posedge clk);
            #1;
            e_out_ready = 1'b0;
            vecs++;
            if (e_out_valid !== 1'b0 || e_in_ready !== 1'b1) begin
                errs++;
                $display("FAIL nmax6_rel%0d: v=%0b rdy=%0b want 0/1",
                         i, e_out_valid, e_in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit ok;
        int bad;
        send(27, 3);
        wait_out(300, lat, ok);
        vecs++;
        if (out_valid !== 1'b1 || out_data !== 25'd98304) begin
            errs++;
            $display("FAIL bp_data: valid=%0b data=%0d want 1/98304",
                     out_valid, out_data);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_data !== 25'd98304 ||
                in_ready !== 1'b0) bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL bp_hold: %0d unstable cycles want 0", bad);
        end
        take();
        vecs++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL bp_hs: valid=%0b rdy=%0b want 0/1",
                     out_valid, in_ready);
        end
        vecs++;
        if (out_data !== 25'd98304) begin
            errs++;
            $display("FAIL bp_keep: data=%0d want 98304", out_data);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit ok;
        send(500, 5);
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if (in_ready !== 1'b0) begin
            errs++;
            $display("FAIL mid_busy: rdy=%0b want 0", in_ready);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vecs++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL mid_rst: rdy=%0b valid=%0b want 1/0",
                     in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        vecs++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL mid_idle: rdy=%0b valid=%0b want 1/0",
                     in_ready, out_valid);
        end
        send(0, 4);
        wait_out(300, lat, ok);
        vecs++;
        if (out_valid !== 1'b1 || out_data !== 25'd0 ||
            out_err !== 1'b0) begin
            errs++;
            $display("FAIL zero: v=%0b d=%0d e=%0b want 1/0/0",
                     out_valid, out_data, out_err);
        end
        take();
    endtask

    initial begin
        test_reset();
        test_exact();
        test_sqrt_and_n1();
        test_seventh();
        test_err();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
